// File: rtl/rk2_var2_frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rk2_var2_frame_receiver_pkg
//  Brief    : Shared types and constants for the byte-serial frame receiver.
//  Revision : 1.0  initial release
// ============================================================================
package rk2_var2_frame_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DHI  = 3'd1,
    ST_DLO  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Header + data_hi + data_lo
  localparam int unsigned c_frame_len    = 3;
  localparam logic [3:0]  c_sync_default = 4'hC;

endpackage
`default_nettype wire

// File: rtl/rk2_var2_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : rk2_var2_frame_receiver
//  Brief    : Slave-side deserializer: header + two data bytes under active-low
//             chip select; registered ack/err pulses and held 16-bit payload.
//  Revision : 1.0  initial release
// ============================================================================
module rk2_var2_frame_receiver
  import rk2_var2_frame_receiver_pkg::*;
#(
  parameter logic [3:0] SYNC = c_sync_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [7:0]  d_in,
  output logic        ack,
  output logic        err,
  output logic [15:0] d_out
);

  state_t     r_state;
  logic [7:0] r_data_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_data_hi <= 8'h00;
      d_out     <= 16'h0000;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Pulses are one cycle wide unless re-asserted below
      ack <= 1'b0;
      err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!cs) begin
            if (d_in[7:4] == SYNC) begin
              r_state <= ST_DHI;
            end else begin
              r_state <= ST_ERR;
              err     <= 1'b1;
            end
          end
        end
        ST_DHI: begin
          if (!cs) begin
            r_data_hi <= d_in;
            r_state   <= ST_DLO;
          end else begin
            err     <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_DLO: begin
          if (!cs) begin
            d_out   <= {r_data_hi, d_in};
            ack     <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            err     <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          // A byte beyond the frame length makes the frame overlong
          if (!cs) begin
            err     <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (cs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rk2_var2_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rk2_var2_frame_receiver
//  Brief    : Self-checking bench: per-cycle vector table with a result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rk2_var2_frame_receiver;

  typedef struct {
    logic        cs;
    logic [7:0]  d;
    logic        ack;
    logic        err;
    logic [15:0] dout;
  } vec_t;

  typedef struct {
    string       name;
    logic        ack;
    logic        err;
    logic [15:0] dout;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cs;
  logic [7:0]  d_in;
  logic        ack;
  logic        err;
  logic [15:0] d_out;

  int errors = 0;
  int checks = 0;

  vec_t vecs[$];
  exp_t sb[$];

  rk2_var2_frame_receiver #(.SYNC(4'hC)) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .d_in (d_in),
    .ack  (ack),
    .err  (err),
    .d_out(d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic c, input logic [7:0] d, input logic a,
                     input logic e, input logic [15:0] o);
    vec_t v;
    v.cs = c; v.d = d; v.ack = a; v.err = e; v.dout = o;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string name, input logic a,
                               input logic e, input logic [15:0] o);
    checks++;
    if (ack !== a || err !== e || d_out !== o) begin
      errors++;
      $display("FAIL %s: got ack=%b err=%b d_out=%h, want ack=%b err=%b d_out=%h",
               name, ack, err, d_out, a, e, o);
    end
  endtask

  // Drive one byte cycle, queue its expectation, then compare after the edge
  task automatic step(input string name, input logic c, input logic [7:0] d,
                      input logic a, input logic e, input logic [15:0] o);
    exp_t x;
    @(negedge clk);
    cs   = c;
    d_in = d;
    x.name = name; x.ack = a; x.err = e; x.dout = o;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_outputs(x.name, x.ack, x.err, x.dout);
  endtask

  initial begin
    rst  = 1'b0;
    cs   = 1'b1;
    d_in = 8'h00;

    // Good frame, then idle
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 8'hCA, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 8'hFF, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 8'h01, 1'b1, 1'b0, 16'hFF01);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'hFF01);
    // Short frame ending in DLO
    add(1'b0, 8'hCC, 1'b0, 1'b0, 16'hFF01);
    add(1'b0, 8'h12, 1'b0, 1'b0, 16'hFF01);
    add(1'b1, 8'h00, 1'b0, 1'b1, 16'hFF01);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'hFF01);
    // Short frame ending in DHI
    add(1'b0, 8'hC7, 1'b0, 1'b0, 16'hFF01);
    add(1'b1, 8'h00, 1'b0, 1'b1, 16'hFF01);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'hFF01);
    // Bad header; remaining bytes ignored
    add(1'b0, 8'h3A, 1'b0, 1'b1, 16'hFF01);
    add(1'b0, 8'h11, 1'b0, 1'b0, 16'hFF01);
    add(1'b0, 8'h22, 1'b0, 1'b0, 16'hFF01);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'hFF01);
    // Near-miss header nibble
    add(1'b0, 8'hDC, 1'b0, 1'b1, 16'hFF01);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'hFF01);
    // Overlong frame
    add(1'b0, 8'hC0, 1'b0, 1'b0, 16'hFF01);
    add(1'b0, 8'hAB, 1'b0, 1'b0, 16'hFF01);
    add(1'b0, 8'hCD, 1'b1, 1'b0, 16'hABCD);
    add(1'b0, 8'hEF, 1'b0, 1'b1, 16'hABCD);
    add(1'b0, 8'h99, 1'b0, 1'b0, 16'hABCD);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'hABCD);
    // Two frames with a single idle cycle between
    add(1'b0, 8'hCF, 1'b0, 1'b0, 16'hABCD);
    add(1'b0, 8'h12, 1'b0, 1'b0, 16'hABCD);
    add(1'b0, 8'h34, 1'b1, 1'b0, 16'h1234);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'h1234);
    add(1'b0, 8'hC3, 1'b0, 1'b0, 16'h1234);
    add(1'b0, 8'h56, 1'b0, 1'b0, 16'h1234);
    add(1'b0, 8'h78, 1'b1, 1'b0, 16'h5678);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'h5678);

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].cs, vecs[i].d, vecs[i].ack,
           vecs[i].err, vecs[i].dout);

    // Asynchronous reset in the middle of a valid frame
    step("mid_hdr", 1'b0, 8'hC5, 1'b0, 1'b0, 16'h5678);
    step("mid_dhi", 1'b0, 8'h12, 1'b0, 1'b0, 16'h5678);
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    cs  = 1'b1;
    rst = 1'b1;
    step("post_rst_hdr", 1'b0, 8'hC5, 1'b0, 1'b0, 16'h0000);
    step("post_rst_dhi", 1'b0, 8'h12, 1'b0, 1'b0, 16'h0000);
    step("post_rst_dlo", 1'b0, 8'h34, 1'b1, 1'b0, 16'h1234);
    step("post_rst_idle", 1'b1, 8'h00, 1'b0, 1'b0, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rk2_var2_frame_receiver.md
# rk2_var2_frame_receiver

Byte-serial frame receiver: while chip select is active (low), one byte per clock is sampled from `d_in`. A valid frame is one header byte followed by two data bytes. On a good frame the receiver presents the 16-bit payload on `d_out` and pulses `ack`. Malformed frames pulse `err`. The block sits behind a simple parallel byte bus as the slave-side deserializer.

## Interface
- `SYNC`, default 4'hC: required value of `header[7:4]`.
- `clk`, in, 1: system clock; all sampling happens on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `cs`, in, 1: chip select, active-low; frame boundary.
- `d_in`, in, 8: input byte, sampled each rising edge while `cs`=0.
- `ack`, out, 1: one-cycle pulse on good-frame completion.
- `err`, out, 1: one-cycle pulse on frame error.
- `d_out`, out, 16: last good payload, `{data_hi, data_lo}`; holds between frames.

## Operation
- Frame format: byte0 = header, byte1 = data_hi, byte2 = data_lo.
- Header is valid iff `header[7:4]` = SYNC; `header[3:0]` is don't-care.
- States:
  - IDLE:
    - `cs`=1 → stay.
    - `cs`=0 → sample header. If valid → DHI; if invalid → ERR with `err` pulse.
  - DHI:
    - `cs`=0 → latch data_hi → DLO.
    - `cs`=1 → `err` pulse, → IDLE (short frame).
  - DLO:
    - `cs`=0 → load `d_out` = `{data_hi, d_in}`, `ack` pulse, → DONE.
    - `cs`=1 → `err` pulse, → IDLE.
  - DONE:
    - `cs`=1 → IDLE.
    - `cs`=0 → ERR with `err` pulse (overlong frame; 4th byte is discarded, `d_out` unchanged).
  - ERR:
    - `cs`=1 → IDLE.
    - `cs`=0 → stay. No further pulses; bytes are ignored.
- `d_out` changes only on a good frame. Errors never modify it.
- `ack` and `err` are never high in the same cycle.
- Data bytes are stored unchecked. No parity or checksum.

## Timing
- Reset values: `ack`=0, `err`=0, `d_out`=16'h0000, state IDLE, data_hi register = 0.
- Reset mid-frame aborts the frame immediately with no `err`.
- Outputs are registered.
- `ack` rises at the clock edge that samples byte2, i.e. the 3rd edge with `cs`=0. `d_out` updates at that same edge.
- `ack` is high for exactly one cycle.
- `err` for a bad header is high in the cycle after the edge that sampled the header. For a short or overlong frame, it is high in the cycle after the edge that detected the condition. Always one cycle wide.
- `cs` is sampled synchronously; no glitch filtering.
- One idle cycle (`cs`=1) between frames is sufficient. Back-to-back frames without a `cs`=1 cycle are treated as overlong.

## Structure
- Shared package holds:
  - state enum {IDLE, DHI, DLO, DONE, ERR};
  - `FRAME_LEN` = 3;
  - default SYNC constant 4'hC.
- Single module: one FSM, one 8-bit data_hi register, one 16-bit output register, and `ack`/`err` registers.
- No sub-module is warranted.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → `ack`=0, `err`=0, `d_out`=16'h0000. Then release.
- Good frame: `cs`=0 for 3 cycles with 8'hCA, 8'hFF, 8'h01, then `cs`=1 → `d_out`=16'hFF01 and a single `ack` pulse after the 3rd edge. `err` stays 0.
- Short frame: `cs`=0 for 2 cycles with 8'hCC, 8'h12, then `cs`=1 → single `err` pulse. `d_out` remains 16'hFF01. No `ack`.
- Bad header: `cs`=0 with 8'h3A, 8'h11, 8'h22 → `err` pulse after the 1st edge only. `d_out` unchanged.
- Overlong: 8'hC0, 8'hAB, 8'hCD, 8'hEF with `cs`=0 for 4 cycles → `ack` with `d_out`=16'hABCD, followed by an `err` pulse one cycle later. `d_out` stays 16'hABCD.
- Async reset mid-frame: assert `rst`=0 after byte1 of a valid frame → outputs immediately 0. After release, a new good frame C5/12/34 gives `d_out`=16'h1234 with an `ack` pulse.
